// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: WS2812 one-wire NRZ line driver.
// Turns the current serial bit from the frame transmitter into the WS2812
// high/low waveform on dout. It paces the transmitter with new_bit_rqst and
// new_frame_rqst, holds the line low for the latch period after each set,
// and then pulses set_done.
// Optional feature: define WS2812_CONTINUOUS_EN to restart the next set
// straight after the latch period instead of returning to IDLE.
// All outputs are registered. Each output register is loaded from the
// next-state values, so the outputs line up with the state they describe.

module ws2812_bit_encoder #(
  parameter int T0H_CYC        = 20,
  parameter int T1H_CYC        = 40,
  parameter int BIT_CYC        = 62,
  parameter int LATCH_CYC      = 3000,
  parameter int BITS_PER_FRAME = 24,
  parameter int FRAMES_PER_SET = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_in,
  output logic new_bit_rqst,
  output logic new_frame_rqst,
  output logic dout,
  output logic busy,
  output logic set_done
);

  localparam int PH_W    = (BIT_CYC > 1)        ? $clog2(BIT_CYC)        : 1;
  localparam int BIT_W   = (BITS_PER_FRAME > 1) ? $clog2(BITS_PER_FRAME) : 1;
  localparam int FRAME_W = (FRAMES_PER_SET > 1) ? $clog2(FRAMES_PER_SET) : 1;
  localparam int LATCH_W = (LATCH_CYC > 1)      ? $clog2(LATCH_CYC)      : 1;

  localparam logic [PH_W-1:0]    PH_ZERO    = PH_W'(0);
  localparam logic [PH_W-1:0]    PH_ONE     = PH_W'(1);
  localparam logic [PH_W-1:0]    PH_LAST    = PH_W'(BIT_CYC - 1);
  localparam logic [PH_W-1:0]    PH_T0H     = PH_W'(T0H_CYC);
  localparam logic [PH_W-1:0]    PH_T1H     = PH_W'(T1H_CYC);
  localparam logic [BIT_W-1:0]   BIT_ZERO   = BIT_W'(0);
  localparam logic [BIT_W-1:0]   BIT_ONE    = BIT_W'(1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BITS_PER_FRAME - 1);
  localparam logic [FRAME_W-1:0] FRAME_ZERO = FRAME_W'(0);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SET - 1);
  localparam logic [LATCH_W-1:0] LATCH_ZERO = LATCH_W'(0);
  localparam logic [LATCH_W-1:0] LATCH_ONE  = LATCH_W'(1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BIT   = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [PH_W-1:0]      ph_r, ph_s;
  logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic [FRAME_W-1:0]   frame_cnt_r, frame_cnt_s;
  logic [LATCH_W-1:0]   latch_cnt_r, latch_cnt_s;
  logic                 cur_bit_r, cur_bit_s;

  logic                 dout_s;
  logic                 busy_s;
  logic                 bit_rqst_s;
  logic                 frame_rqst_s;
  logic                 done_s;

  // State and counter registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ph_r        <= PH_ZERO;
      bit_cnt_r   <= BIT_ZERO;
      frame_cnt_r <= FRAME_ZERO;
      latch_cnt_r <= LATCH_ZERO;
      cur_bit_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      ph_r        <= ph_s;
      bit_cnt_r   <= bit_cnt_s;
      frame_cnt_r <= frame_cnt_s;
      latch_cnt_r <= latch_cnt_s;
      cur_bit_r   <= cur_bit_s;
    end
  end

  // Next-state and counter sequencing: bit phase, bit/frame counts, latch wait.
  always_comb begin
    state_s     = state_r;
    ph_s        = ph_r;
    bit_cnt_s   = bit_cnt_r;
    frame_cnt_s = frame_cnt_r;
    latch_cnt_s = latch_cnt_r;
    cur_bit_s   = cur_bit_r;
    case (state_r)
      ST_IDLE: begin
        ph_s        = PH_ZERO;
        bit_cnt_s   = BIT_ZERO;
        frame_cnt_s = FRAME_ZERO;
        latch_cnt_s = LATCH_ZERO;
        if (start) begin
          state_s = ST_BIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BIT: begin
        // The bit is sampled once, in the first phase cycle, so upstream
        // has the whole rqst-to-capture gap to present it.
        if (ph_r == PH_ZERO) begin
          cur_bit_s = bit_in;
        end else begin
          cur_bit_s = cur_bit_r;
        end
        if (ph_r == PH_LAST) begin
          ph_s = PH_ZERO;
          if (bit_cnt_r != BIT_LAST) begin
            bit_cnt_s = bit_cnt_r + BIT_ONE;
          end else if (frame_cnt_r != FRAME_LAST) begin
            bit_cnt_s   = BIT_ZERO;
            frame_cnt_s = frame_cnt_r + FRAME_ONE;
          end else begin
            bit_cnt_s   = BIT_ZERO;
            frame_cnt_s = FRAME_ZERO;
            latch_cnt_s = LATCH_ZERO;
            state_s     = ST_LATCH;
          end
        end else begin
          ph_s = ph_r + PH_ONE;
        end
      end
      ST_LATCH: begin
        if (latch_cnt_r == LATCH_LAST) begin
          latch_cnt_s = LATCH_ZERO;
          ph_s        = PH_ZERO;
          bit_cnt_s   = BIT_ZERO;
          frame_cnt_s = FRAME_ZERO;
`ifdef WS2812_CONTINUOUS_EN
          state_s     = ST_BIT;
`else
          state_s     = ST_IDLE;
`endif
        end else begin
          latch_cnt_s = latch_cnt_r + LATCH_ONE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        ph_s        = PH_ZERO;
        bit_cnt_s   = BIT_ZERO;
        frame_cnt_s = FRAME_ZERO;
        latch_cnt_s = LATCH_ZERO;
        cur_bit_s   = 1'b0;
      end
    endcase
  end

  // Output decode from the next state: waveform level, rqst/done pulses, busy.
  always_comb begin
    dout_s       = 1'b0;
    bit_rqst_s   = 1'b0;
    frame_rqst_s = 1'b0;
    done_s       = 1'b0;
    busy_s       = (state_s != ST_IDLE);
    case (state_s)
      ST_BIT: begin
        // Phase 0 is always high, and T0H_CYC >= 2 keeps it in the short
        // pulse. So the bit only matters from phase 1 on, where cur_bit_s
        // already holds the captured value.
        if (ph_s < PH_T0H) begin
          dout_s = 1'b1;
        end else if (ph_s < PH_T1H) begin
          dout_s = cur_bit_s;
        end else begin
          dout_s = 1'b0;
        end
        // The rqst pulses are high during the last phase cycle, so upstream
        // advances on the edge that starts the next bit.
        if (ph_s == PH_LAST) begin
          if (bit_cnt_s != BIT_LAST) begin
            bit_rqst_s = 1'b1;
          end else begin
            frame_rqst_s = 1'b1;
          end
        end else begin
          bit_rqst_s   = 1'b0;
          frame_rqst_s = 1'b0;
        end
      end
      ST_LATCH: begin
        if (latch_cnt_s == LATCH_LAST) begin
          done_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      ST_IDLE: begin
        dout_s = 1'b0;
      end
      default: begin
        dout_s = 1'b0;
      end
    endcase
  end

  // Registered outputs, forced quiet by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout           <= 1'b0;
      busy           <= 1'b0;
      new_bit_rqst   <= 1'b0;
      new_frame_rqst <= 1'b0;
      set_done       <= 1'b0;
    end else begin
      dout           <= dout_s;
      busy           <= busy_s;
      new_bit_rqst   <= bit_rqst_s;
      new_frame_rqst <= frame_rqst_s;
      set_done       <= done_s;
    end
  end

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// tb_ws2812_bit_encoder: directed, self-checking bench for ws2812_bit_encoder
// with short timing parameters. A bench-side shift register acts as the
// upstream transmitter. Expected waveforms come from the bit patterns.
`timescale 1ns/1ps

module tb_ws2812_bit_encoder;

  localparam int T0H   = 2;
  localparam int T1H   = 4;
  localparam int BITC  = 6;
  localparam int LATCH = 10;
  localparam int BPF   = 24;
  localparam int FPS   = 8;
  localparam int SET_BIT_CYC = BPF * FPS * BITC;     // 1152
  localparam int SET_CYC     = SET_BIT_CYC + LATCH;  // 1162

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic bit_in;
  logic new_bit_rqst;
  logic new_frame_rqst;
  logic dout;
  logic busy;
  logic set_done;

  int n_checks = 0;
  int n_fail   = 0;

  ws2812_bit_encoder #(
    .T0H_CYC        (T0H),
    .T1H_CYC        (T1H),
    .BIT_CYC        (BITC),
    .LATCH_CYC      (LATCH),
    .BITS_PER_FRAME (BPF),
    .FRAMES_PER_SET (FPS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .bit_in         (bit_in),
    .new_bit_rqst   (new_bit_rqst),
    .new_frame_rqst (new_frame_rqst),
    .dout           (dout),
    .busy           (busy),
    .set_done       (set_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Checks that every output is 0 for n cycles.
  task automatic quiet_cycles(input string tag, input int n);
    int active;
    active = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ((dout !== 1'b0) || (busy !== 1'b0) || (new_bit_rqst !== 1'b0) ||
          (new_frame_rqst !== 1'b0) || (set_done !== 1'b0)) begin
        active++;
      end
    end
    check_val(tag, active, 0);
  endtask

  // Starts one set with pattern pat in every frame and checks it cycle by cycle.
  // restart_a/b re-pulse start at those cycle indices. If abort_at >= 0,
  // rst is raised at that cycle and the task returns one cycle after the reset edge.
  task automatic run_set(input string name, input logic [23:0] pat,
                         input int restart_a, input int restart_b, input int abort_at);
    logic [23:0] sr;
    logic [23:0] dec;
    logic        bv, e_dout, e_brq, e_frq, e_done;
    int p, b, bi, hi_cnt;
    int dout_err, brq_err, frq_err, done_err, busy_err;
    int n_brq, n_frq, n_done;
    dout_err = 0; brq_err = 0; frq_err = 0; done_err = 0; busy_err = 0;
    n_brq = 0; n_frq = 0; n_done = 0; hi_cnt = 0; dec = 24'h000000;
    sr = pat;
    bit_in = sr[23];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < SET_CYC; i++) begin
      p  = i % BITC;
      b  = i / BITC;
      bi = b % BPF;
      if (i < SET_BIT_CYC) begin
        bv     = pat[23 - bi];
        e_dout = (p < T0H) || ((p < T1H) && bv);
        e_brq  = (p == BITC - 1) && (bi != BPF - 1);
        e_frq  = (p == BITC - 1) && (bi == BPF - 1);
      end else begin
        e_dout = 1'b0;
        e_brq  = 1'b0;
        e_frq  = 1'b0;
      end
      e_done = (i == SET_CYC - 1);
      if (dout !== e_dout) dout_err++;
      if (new_bit_rqst !== e_brq) brq_err++;
      if (new_frame_rqst !== e_frq) frq_err++;
      if (set_done !== e_done) done_err++;
      if (busy !== 1'b1) busy_err++;
      if (new_bit_rqst === 1'b1) n_brq++;
      if (new_frame_rqst === 1'b1) n_frq++;
      if (set_done === 1'b1) n_done++;
      // Decode the line: a long high pulse is a '1'.
      if (i < SET_BIT_CYC) begin
        if (dout === 1'b1) hi_cnt++;
        if (p == BITC - 1) begin
          dec    = {dec[22:0], (hi_cnt >= 3)};
          hi_cnt = 0;
          if (bi == BPF - 1) check_val({name, "_frame_word"}, {8'h00, dec}, {8'h00, pat});
        end
      end
      // Upstream transmitter model.
      if (new_bit_rqst === 1'b1) begin
        sr     = {sr[22:0], 1'b0};
        bit_in = sr[23];
      end
      if (new_frame_rqst === 1'b1) begin
        sr     = pat;
        bit_in = sr[23];
      end
      if (i == abort_at) begin
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        break;
      end
      start = (i == restart_a) || (i == restart_b);
      @(negedge clk);
    end
    start = 1'b0;
    check_val({name, "_dout_wave"}, dout_err, 0);
    check_val({name, "_bit_rqst_timing"}, brq_err, 0);
    check_val({name, "_frame_rqst_timing"}, frq_err, 0);
    check_val({name, "_busy_during_set"}, busy_err, 0);
    if (abort_at < 0) begin
      check_val({name, "_set_done_timing"}, done_err, 0);
      check_val({name, "_bit_rqst_count"}, n_brq, 184);
      check_val({name, "_frame_rqst_count"}, n_frq, 8);
      check_val({name, "_set_done_count"}, n_done, 1);
      check_val({name, "_busy_after_done"}, busy, 0);
      check_val({name, "_dout_after_done"}, dout, 0);
      check_val({name, "_done_one_cycle"}, set_done, 0);
      @(negedge clk);
      check_val({name, "_still_idle"}, {30'd0, busy, dout}, 0);
    end else begin
      check_val({name, "_done_before_abort"}, n_done, 0);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bit_in = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_dout", dout, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_bit_rqst", new_bit_rqst, 0);
    check_val("reset_frame_rqst", new_frame_rqst, 0);
    check_val("reset_set_done", set_done, 0);
    rst = 1'b0;
    quiet_cycles("idle_50_quiet", 50);

    run_set("zeros",   24'h000000, -1, -1, -1);
    run_set("ones",    24'hFFFFFF, -1, -1, -1);
    run_set("pattern", 24'hA5C3F0, -1, -1, -1);
    run_set("restart", 24'h3C5A96, 300, 1155, -1);

    // Abort at frame 3, bit 10, phase 2.
    run_set("abort", 24'h5A5A5A, -1, -1, (3 * BPF + 10) * BITC + 2);
    check_val("abort_dout", dout, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_pulses", {29'd0, new_bit_rqst, new_frame_rqst, set_done}, 0);
    rst = 1'b0;
    quiet_cycles("abort_quiet", 30);
    run_set("after_reset", 24'hA5C3F0, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
